// File: rtl/cmd_fetch_ctrl_if.sv
// Command-fetch bus: FIFO pop side plus the assembled-command valid/ready side.
// master = fetch sequencer, slave = FIFO + dispatcher environment.
interface cmd_fetch_ctrl_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PAYLOAD = 3
);
  logic                              o_fifo_rd_en;
  logic [DATA_WIDTH-1:0]             i_fifo_rd_data;
  logic                              i_fifo_empty;
  logic                              o_cmd_valid;
  logic                              i_cmd_ready;
  logic [7:0]                        o_cmd_opcode;
  logic [7:0]                        o_cmd_id;
  logic [3:0]                        o_cmd_len;
  logic [MAX_PAYLOAD*DATA_WIDTH-1:0] o_cmd_payload;
  logic                              o_busy;
  logic                              o_err_len;
  logic [15:0]                       o_cmd_count;

  modport master (
    output o_fifo_rd_en, o_cmd_valid, o_cmd_opcode, o_cmd_id, o_cmd_len,
           o_cmd_payload, o_busy, o_err_len, o_cmd_count,
    input  i_fifo_rd_data, i_fifo_empty, i_cmd_ready
  );

  modport slave (
    input  o_fifo_rd_en, o_cmd_valid, o_cmd_opcode, o_cmd_id, o_cmd_len,
           o_cmd_payload, o_busy, o_err_len, o_cmd_count,
    output i_fifo_rd_data, i_fifo_empty, i_cmd_ready
  );
endinterface

// File: rtl/cmd_fetch_ctrl.sv
// Command fetch sequencer: pops a header word from the uCode command FIFO, then
// the number of payload words it announces, and presents the assembled command
// to the GEMM dispatcher on valid/ready. Oversized commands are drained and
// flagged in a sticky error bit.
// Optional macro CMD_FETCH_STATS_EN: enables the dispatched-command counter on
// o_cmd_count and an internal saturating FIFO-stall counter; when undefined,
// o_cmd_count is tied to zero.
module cmd_fetch_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PAYLOAD = 3
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  cmd_fetch_ctrl_if.master   bus
);

  localparam int         PAYLOAD_W = MAX_PAYLOAD * DATA_WIDTH;
  localparam logic [3:0] MAX_LEN   = 4'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    IDLE, HDR_WAIT, PL_REQ, PL_WAIT, DISPATCH, DR_REQ, DR_WAIT
  } state_t;

  state_t                 state;
  logic                   armed;
  logic [3:0]             idx;
  logic [3:0]             drain_cnt;
  logic [7:0]             opcode;
  logic [7:0]             id;
  logic [3:0]             len;
  logic [PAYLOAD_W-1:0]   payload;
  logic                   valid;
  logic                   err_len;

  logic                   pop_slot;
  logic                   rd_en;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic [3:0]             hdr_len;
  logic                   unused_hdr_bits;

  assign rd_data         = bus.i_fifo_rd_data;
  assign hdr_len         = rd_data[11:8];
  assign unused_hdr_bits = ^{rd_data[15:12], rd_data[7:0]};

  // The pop decision looks at the live registered empty flag, so it is decoded
  // from state rather than registered. 'armed' keeps the first cycle after reset
  // free of pops so every output reads zero in that cycle.
  assign pop_slot = armed && (state == IDLE || state == PL_REQ || state == DR_REQ);
  assign rd_en    = i_reset_n && pop_slot && !bus.i_fifo_empty;

  // Fetch/assemble/dispatch sequencer with registered command outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      armed     <= 1'b0;
      idx       <= '0;
      drain_cnt <= '0;
      opcode    <= '0;
      id        <= '0;
      len       <= '0;
      payload   <= '0;
      valid     <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (rd_en) state <= HDR_WAIT;
        end
        HDR_WAIT: begin
          opcode  <= rd_data[31:24];
          id      <= rd_data[23:16];
          len     <= hdr_len;
          payload <= '0;
          idx     <= '0;
          if (hdr_len > MAX_LEN) begin
            err_len   <= 1'b1;
            drain_cnt <= hdr_len;
            state     <= DR_REQ;
          end else if (hdr_len == 4'd0) begin
            valid <= 1'b1;
            state <= DISPATCH;
          end else begin
            state <= PL_REQ;
          end
        end
        PL_REQ: begin
          if (rd_en) state <= PL_WAIT;
        end
        PL_WAIT: begin
          for (int unsigned k = 0; k < MAX_PAYLOAD; k++) begin
            if (idx == 4'(k)) payload[k*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
          end
          idx <= idx + 4'd1;
          if (idx + 4'd1 == len) begin
            valid <= 1'b1;
            state <= DISPATCH;
          end else begin
            state <= PL_REQ;
          end
        end
        DISPATCH: begin
          if (bus.i_cmd_ready) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        DR_REQ: begin
          if (rd_en) state <= DR_WAIT;
        end
        DR_WAIT: begin
          drain_cnt <= drain_cnt - 4'd1;
          if (drain_cnt == 4'd1) state <= IDLE;
          else                   state <= DR_REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_fifo_rd_en  = rd_en;
  assign bus.o_cmd_valid   = valid;
  assign bus.o_cmd_opcode  = opcode;
  assign bus.o_cmd_id      = id;
  assign bus.o_cmd_len     = len;
  assign bus.o_cmd_payload = payload;
  assign bus.o_busy        = (state != IDLE);
  assign bus.o_err_len     = err_len;

`ifdef CMD_FETCH_STATS_EN
  logic [15:0] cmd_count;
  logic [15:0] stall_cnt;
  logic        handshake;
  logic        stalled;

  assign handshake = (state == DISPATCH) && valid && bus.i_cmd_ready;
  assign stalled   = (state == PL_REQ || state == DR_REQ) && bus.i_fifo_empty;

  // Dispatched-command counter (wraps) and saturating FIFO-stall counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cmd_count <= '0;
      stall_cnt <= '0;
    end else begin
      if (handshake) cmd_count <= cmd_count + 16'd1;
      if (stalled && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.o_cmd_count = cmd_count;
`else
  assign bus.o_cmd_count = '0;
`endif

  // A pop is never issued against an empty FIFO.
  assert property (@(posedge i_clk) disable iff (!i_reset_n)
                   !(bus.o_fifo_rd_en && bus.i_fifo_empty));

endmodule

// File: tb/tb_cmd_fetch_ctrl.sv
// Testbench for cmd_fetch_ctrl: FIFO model with registered data/empty, a
// scoreboard of expected commands, and a negedge monitor that checks every
// presented command against the scoreboard head.
`timescale 1ns/1ps
module tb_cmd_fetch_ctrl;

  localparam int DW = 32;
  localparam int MP = 3;
`ifdef CMD_FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cmd_fetch_ctrl_if #(.DATA_WIDTH(DW), .MAX_PAYLOAD(MP)) bus ();

  cmd_fetch_ctrl #(.DATA_WIDTH(DW), .MAX_PAYLOAD(MP)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       op;
    logic [7:0]       id;
    logic [3:0]       len;
    logic [MP*DW-1:0] pl;
  } cmd_t;

  cmd_t          exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int            rd_hist[$];
  int            cyc        = 0;
  int            last_rd    = 0;
  int            last_vrise = 0;
  int            disp_cnt   = 0;
  int            errors     = 0;
  int            checks     = 0;
  logic          vprev      = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: registered read data and registered empty flag
  always @(posedge clk) begin
    if (bus.o_fifo_rd_en && fifo_q.size() > 0) bus.i_fifo_rd_data <= fifo_q.pop_front();
    bus.i_fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop rules, valid latency, and scoreboard comparison
  always @(negedge clk) begin
    if (bus.o_fifo_rd_en) begin
      chk("rd_while_empty", bus.i_fifo_empty, 1'b0);
      last_rd = cyc;
      rd_hist.push_back(cyc);
    end
    if (bus.o_cmd_valid) begin
      if (!vprev) begin
        last_vrise = cyc;
        chk("valid_latency", cyc - last_rd, 2);
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 opcode=%0h expected no command", bus.o_cmd_opcode);
      end else begin
        chk("cmd_opcode",  bus.o_cmd_opcode,  exp_q[0].op);
        chk("cmd_id",      bus.o_cmd_id,      exp_q[0].id);
        chk("cmd_len",     bus.o_cmd_len,     exp_q[0].len);
        chk("cmd_payload", bus.o_cmd_payload, exp_q[0].pl);
        if (bus.i_cmd_ready) begin
          void'(exp_q.pop_front());
          disp_cnt++;
        end
      end
    end
    vprev = bus.o_cmd_valid;
  end

  function automatic logic [15:0] exp_count(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [7:0] op, input logic [7:0] id,
                          input logic [3:0] len, input logic [MP*DW-1:0] pl);
    cmd_t c;
    c.op = op; c.id = id; c.len = len; c.pl = pl;
    exp_q.push_back(c);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (k < budget && !(bus.o_busy == 1'b0 && bus.o_cmd_valid == 1'b0 &&
                           fifo_q.size() == 0 && exp_q.size() == 0)) begin
      tick(1);
      k++;
    end
    chk({name, "_done"}, (k < budget), 1'b1);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_rd_en"},   bus.o_fifo_rd_en,  1'b0);
    chk({name, "_valid"},   bus.o_cmd_valid,   1'b0);
    chk({name, "_opcode"},  bus.o_cmd_opcode,  8'h00);
    chk({name, "_id"},      bus.o_cmd_id,      8'h00);
    chk({name, "_len"},     bus.o_cmd_len,     4'h0);
    chk({name, "_payload"}, bus.o_cmd_payload, '0);
    chk({name, "_busy"},    bus.o_busy,        1'b0);
    chk({name, "_err_len"}, bus.o_err_len,     1'b0);
    chk({name, "_count"},   bus.o_cmd_count,   16'h0000);
  endtask

  initial begin
    int n;
    int d0;
    bus.i_cmd_ready = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check_zero("reset");

    // len=0 command preloaded during reset
    fifo_q.push_back(32'h01070000);
    push_exp(8'h01, 8'h07, 4'd0, '0);
    rd_hist.delete();
    rst_n = 1'b1;
    wait_idle("t1", 100);
    chk("t1_rd_pulses", rd_hist.size(), 1);
    chk("t1_valid_after_rd", last_vrise - rd_hist[0], 2);
    chk("t1_count", bus.o_cmd_count, exp_count(1));

    // len=3 command, all words available
    rd_hist.delete();
    fifo_q.push_back(32'h02030300);
    fifo_q.push_back(32'h0000000A);
    fifo_q.push_back(32'h0000000B);
    fifo_q.push_back(32'h0000000C);
    push_exp(8'h02, 8'h03, 4'd3, 96'h0000000C_0000000B_0000000A);
    wait_idle("t2", 100);
    chk("t2_rd_pulses", rd_hist.size(), 4);
    chk("t2_rd_span", rd_hist[3] - rd_hist[0], 6);
    chk("t2_valid_after_first_rd", last_vrise - rd_hist[0], 8);
    chk("t2_count", bus.o_cmd_count, exp_count(2));

    // same command with dispatcher back-pressure for 10 cycles
    rd_hist.delete();
    bus.i_cmd_ready = 1'b0;
    fifo_q.push_back(32'h02030300);
    fifo_q.push_back(32'h0000000A);
    fifo_q.push_back(32'h0000000B);
    fifo_q.push_back(32'h0000000C);
    push_exp(8'h02, 8'h03, 4'd3, 96'h0000000C_0000000B_0000000A);
    n = 0;
    while (n < 40 && bus.o_cmd_valid !== 1'b1) begin
      tick(1);
      n++;
    end
    chk("t3_valid_seen", (n < 40), 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t3_hold_valid", bus.o_cmd_valid, 1'b1);
      chk("t3_hold_no_rd", bus.o_fifo_rd_en, 1'b0);
    end
    chk("t3_rd_pulses", rd_hist.size(), 4);
    d0 = disp_cnt;
    bus.i_cmd_ready = 1'b1;
    wait_idle("t3", 50);
    chk("t3_single_dispatch", disp_cnt - d0, 1);
    chk("t3_count", bus.o_cmd_count, exp_count(3));

    // len=2 header, then FIFO starved for 20 cycles
    rd_hist.delete();
    fifo_q.push_back(32'h11220200);
    push_exp(8'h11, 8'h22, 4'd2, 96'h00000000_00002222_00001111);
    tick(4);
    for (int i = 0; i < 20; i++) begin
      chk("t4_stall_busy", bus.o_busy, 1'b1);
      chk("t4_stall_no_rd", bus.o_fifo_rd_en, 1'b0);
      tick(1);
    end
    chk("t4_rd_pulses_stalled", rd_hist.size(), 1);
    fifo_q.push_back(32'h00001111);
    fifo_q.push_back(32'h00002222);
    wait_idle("t4", 100);
    chk("t4_err_len_clear", bus.o_err_len, 1'b0);
    chk("t4_count", bus.o_cmd_count, exp_count(4));

    // oversized len=15 command drained, then a good len=0 command
    rd_hist.delete();
    d0 = disp_cnt;
    fifo_q.push_back(32'h05000F00);
    for (int i = 0; i < 15; i++) fifo_q.push_back(32'h00000100 + 32'(i));
    fifo_q.push_back(32'h09080000);
    push_exp(8'h09, 8'h08, 4'd0, '0);
    wait_idle("t5", 200);
    chk("t5_err_len", bus.o_err_len, 1'b1);
    chk("t5_rd_pulses", rd_hist.size(), 17);
    chk("t5_dispatches", disp_cnt - d0, 1);
    chk("t5_count", bus.o_cmd_count, exp_count(5));

    // reset while waiting for the first payload word of a len=3 command
    rd_hist.delete();
    fifo_q.push_back(32'h03040300);
    fifo_q.push_back(32'h00000011);
    fifo_q.push_back(32'h0A0B0000);
    fifo_q.push_back(32'h0C0D0000);
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      tick(1);
      if (bus.o_fifo_rd_en) n++;
    end
    chk("t6_reached_pl_req", n, 2);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check_zero("t6_reset");
    push_exp(8'h0A, 8'h0B, 4'd0, '0);
    push_exp(8'h0C, 8'h0D, 4'd0, '0);
    rst_n = 1'b1;
    #1;
    chk("t6_no_pop_after_reset", bus.o_fifo_rd_en, 1'b0);
    wait_idle("t6", 100);
    chk("t6_err_len", bus.o_err_len, 1'b0);
    chk("t6_count", bus.o_cmd_count, exp_count(2));

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_fetch_ctrl.md
Name: cmd_fetch_ctrl

Overview:
Sequencer that drains the uCode command FIFO and assembles multi-word commands for the GEMM dispatcher. It pops one header word, then the number of payload words given in the header. It presents the complete command on a valid/ready interface. It sits between the command FIFO (registered read, 1-cycle latency, registered empty flag) and the engine dispatch logic.

Parameters:
DATA_WIDTH, 32, FIFO word width (cmd_buf_width_gp)
MAX_PAYLOAD, 3, maximum payload words per command (1..15)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous active-low reset
o_fifo_rd_en  out  1  pop request to the command FIFO
i_fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid the cycle after the pop
i_fifo_empty  in  1  FIFO empty flag, registered, updates the cycle after a pop
o_cmd_valid  out  1  assembled command available
i_cmd_ready  in  1  dispatcher accepts the command
o_cmd_opcode  out  8  header[31:24]
o_cmd_id  out  8  header[23:16]
o_cmd_len  out  4  payload word count, header[11:8]
o_cmd_payload  out  MAX_PAYLOAD*DATA_WIDTH  payload, word k at bits [k*32 +: 32]; unused words are 0
o_busy  out  1  state != IDLE
o_err_len  out  1  sticky: header len > MAX_PAYLOAD was seen
o_cmd_count  out  16  commands dispatched (see Optional Feature)

Behaviour:
- Reset (synchronous, i_reset_n=0 at posedge):
  - state=IDLE.
  - All outputs 0: rd_en, cmd_valid, opcode, id, len, payload, busy, err_len, cmd_count.
  - Reset mid-command discards the partial command. FIFO pointers are not touched.
- At most one FIFO read is outstanding. rd_en is asserted only for one cycle and only when i_fifo_empty=0 in that cycle. The next pop is considered no earlier than 2 cycles later, so the registered empty flag is always current. Throughput is 1 word per 2 cycles.
- States:
  - IDLE: if !empty, assert rd_en and go to HDR_WAIT.
  - HDR_WAIT: capture the header from rd_data. Clear payload and word index.
    - len > MAX_PAYLOAD: set err_len; drain_cnt=len; go to DRAIN (or IDLE if len=0 is impossible here).
    - len == 0: go to DISPATCH.
    - otherwise: go to PL_REQ.
  - PL_REQ: if !empty, assert rd_en and go to PL_WAIT. Otherwise stay; stalls indefinitely with no timeout.
  - PL_WAIT: store rd_data into payload word[idx]; idx++. If idx+1 == len, go to DISPATCH; else go to PL_REQ.
  - DISPATCH: o_cmd_valid=1.
    - Opcode, id, len and payload are held stable while valid=1 and ready=0.
    - On valid&&ready: valid drops next cycle, cmd_count++ (wraps at 0xFFFF→0), go to IDLE.
    - IDLE can pop the next header the cycle after the handshake, giving a 3-cycle minimum command-to-command gap for len=0.
  - DRAIN: pop and discard drain_cnt words using the same req/wait pacing (DR_REQ/DR_WAIT). Then go to IDLE. No command is issued.
- i_cmd_ready is ignored outside DISPATCH; ready may be held high permanently.
- Header bits [15:12] and [7:0] are reserved and ignored.
- err_len is cleared only by reset.
- The block never asserts rd_en while i_fifo_empty=1 (checked by assertion).

Optional Feature:
CMD_FETCH_STATS_EN
- Defined: o_cmd_count counts accepted commands as described above.
- Also defined: an internal 16-bit stall counter increments each cycle spent in PL_REQ/DR_REQ with empty=1 and saturates at 0xFFFF. It is visible in simulation only.
- Undefined: o_cmd_count is tied to 0 and neither counter is synthesized.

Test Plan:
- Reset, then FIFO preloaded with 0x01070000 (len=0) and ready=1:
  - rd_en pulses once.
  - valid rises 2 cycles after rd_en with opcode=0x01, id=0x07, len=0, payload=0.
  - cmd_count=1.
- Header 0x02030300 (len=3) followed by payload 0xA, 0xB, 0xC:
  - payload = {0xC,0xB,0xA}, valid after 4 rd_en pulses spaced 2 cycles apart.
- Same command with ready held low for 10 cycles:
  - valid and all fields stable for those 10 cycles.
  - No rd_en while waiting.
  - Single dispatch when ready rises.
- Header len=2, then FIFO empty for 20 cycles, then payload words arrive:
  - Stays in PL_REQ with rd_en=0 and busy=1.
  - Completes correctly once the words arrive.
- Header 0x05000F00 (len=15 > 3) followed by 15 words, then a valid len=0 header:
  - err_len=1; 15 words drained; no valid for the bad command.
  - The next command dispatches normally and cmd_count increments once.
- Reset asserted in PL_WAIT of a len=3 command:
  - All outputs 0 next cycle.
  - The following header is parsed from the current FIFO head.
